// File: rtl/if_id_decode_buffer_pkg.sv
// Shared decode constants for the IF/ID boundary and the immediate extender.
// Opcode values and imm_type encodings are defined only here, so that both
// stages agree on what each format code means.
package if_id_decode_buffer_pkg;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Immediate format select presented to the extender
  localparam logic [2:0] I_TYPE = 3'b000;
  localparam logic [2:0] S_TYPE = 3'b001;
  localparam logic [2:0] B_TYPE = 3'b010;
  localparam logic [2:0] J_TYPE = 3'b011;
  localparam logic [2:0] U_TYPE = 3'b100;

endpackage

// File: rtl/if_id_decode_buffer_opcode_predecode.sv
// Combinational opcode pre-decode on the capture path.
// Ports:
//   opcode   in  7  instr[6:0] of the incoming instruction
//   imm_type out 3  immediate format select (I/S/B/J/U)
//   illegal  out 1  opcode is outside the supported set
// R-type (OP) carries no immediate; it reports I_TYPE with illegal=0 so the
// extender output is simply ignored downstream.
module opcode_predecode
  import if_id_decode_buffer_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = I_TYPE;
    illegal  = 1'b0;
    case (opcode)
      OP_IMM, LOAD, JALR: imm_type = I_TYPE;
      STORE:              imm_type = S_TYPE;
      BRANCH:             imm_type = B_TYPE;
      JAL:                imm_type = J_TYPE;
      LUI, AUIPC:         imm_type = U_TYPE;
      OP:                 imm_type = I_TYPE;
      default:            illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode_buffer.sv
// IF/ID boundary stage: 2-entry skid buffer (main + skid) between fetch and
// decode/immediate extension. Instructions are pre-decoded when captured and
// the decode result travels with the entry.
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        fetch handshake; in_ready = ~skid_valid
//   instr_in, pc_in          fetched instruction and its PC
//   flush                    drop everything held and offered this cycle
//   out_valid/out_ready      head handshake toward execute
//   pc_out, unextend_data    head PC and raw instr[31:7] for the extender
//   imm_type, illegal        pre-decoded format / unsupported-opcode flag
//   rs1, rs2, rd, opcode, funct3, funct7   head instruction fields
// Optional (macro IF_ID_PERF_CNT_EN): stall_cnt, flush_cnt counters.
// Parameter ILLEGAL_AS_NOP=0 accepts illegal instructions but never stores them.
module if_id_decode_buffer
  import if_id_decode_buffer_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [24:0]     unextend_data,
  output logic [2:0]      imm_type,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            illegal
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic            main_valid, skid_valid;
  logic [XLEN-1:0] main_pc, main_instr, skid_pc, skid_instr;
  logic [2:0]      main_imm, skid_imm, dec_imm;
  logic            main_ill, skid_ill, dec_ill;
  logic            accept, pop, wr;
  logic            load_main_new, load_main_skid, load_skid;

  opcode_predecode u_predecode (
    .opcode   (instr_in[6:0]),
    .imm_type (dec_imm),
    .illegal  (dec_ill)
  );

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  // An accepted illegal instruction is swallowed when it may not be forwarded.
  assign wr        = accept & (ILLEGAL_AS_NOP | ~dec_ill);

  // Skid full implies in_ready=0, so a skid->main move never races a write.
  assign load_main_skid = ~flush & skid_valid & pop;
  assign load_main_new  = ~flush & ~skid_valid & wr & (~main_valid | pop);
  assign load_skid      = ~flush & ~skid_valid & wr & main_valid & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (pop) skid_valid <= 1'b0;
    end else if (main_valid) begin
      if (wr && !pop)      skid_valid <= 1'b1;
      else if (!wr && pop) main_valid <= 1'b0;
    end else if (wr) begin
      main_valid <= 1'b1;
    end
  end

  // Data registers clear on reset only, so outputs read as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_pc    <= '0;
      main_instr <= '0;
      main_imm   <= I_TYPE;
      main_ill   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_imm   <= I_TYPE;
      skid_ill   <= 1'b0;
    end else begin
      if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
        main_imm   <= skid_imm;
        main_ill   <= skid_ill;
      end else if (load_main_new) begin
        main_pc    <= pc_in;
        main_instr <= instr_in;
        main_imm   <= dec_imm;
        main_ill   <= dec_ill;
      end
      if (load_skid) begin
        skid_pc    <= pc_in;
        skid_instr <= instr_in;
        skid_imm   <= dec_imm;
        skid_ill   <= dec_ill;
      end
    end
  end

  assign pc_out        = main_pc;
  assign unextend_data = main_instr[31:7];
  assign rs1           = main_instr[19:15];
  assign rs2           = main_instr[24:20];
  assign rd            = main_instr[11:7];
  assign opcode        = main_instr[6:0];
  assign funct3        = main_instr[14:12];
  assign funct7        = main_instr[31:25];
  assign imm_type      = main_imm;
  assign illegal       = main_ill;

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_decode_buffer.sv
// Bench for if_id_decode_buffer. Two instances share stimulus: 'a' forwards
// illegal opcodes, 'b' drops them. A queue per instance models the buffer as
// a depth-2 FIFO.
module tb_if_id_decode_buffer;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, flush, out_ready;
  logic [31:0] instr_in, pc_in;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_pc_out;
  logic [24:0] a_ud;
  logic [2:0]  a_imm, a_f3;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [6:0]  a_opc, a_f7;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_pc_out;
  logic [24:0] b_ud;
  logic [2:0]  b_imm, b_f3;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_opc, b_f7;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

  always #5 clk = ~clk;

  if_id_decode_buffer #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .pc_out(a_pc_out),
    .unextend_data(a_ud), .imm_type(a_imm), .rs1(a_rs1), .rs2(a_rs2),
    .rd(a_rd), .opcode(a_opc), .funct3(a_f3), .funct7(a_f7),
    .illegal(a_illegal)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(a_stall), .flush_cnt(a_flush)
`endif
  );

  if_id_decode_buffer #(.XLEN(32), .ILLEGAL_AS_NOP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .pc_out(b_pc_out),
    .unextend_data(b_ud), .imm_type(b_imm), .rs1(b_rs1), .rs2(b_rs2),
    .rd(b_rd), .opcode(b_opc), .funct3(b_f3), .funct7(b_f7),
    .illegal(b_illegal)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(b_stall), .flush_cnt(b_flush)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] qa[$];      // {pc, instr}
  logic [63:0] qb[$];
  logic [31:0] popped[$];  // PCs seen leaving dut_a

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {illegal, imm_type} straight from the opcode table
  function automatic logic [3:0] exp_dec(input logic [31:0] ins);
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return 4'b0000;
      7'b0100011:                         return 4'b0001;
      7'b1100011:                         return 4'b0010;
      7'b1101111:                         return 4'b0011;
      7'b0110111, 7'b0010111:             return 4'b0100;
      7'b0110011:                         return 4'b0000;
      default:                            return 4'b1000;
    endcase
  endfunction

  task automatic check_port(input string tag, input int size, input logic [63:0] head,
                            input logic ir, input logic ov, input logic [31:0] pco,
                            input logic [24:0] ud, input logic [2:0] it, input logic il,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                            input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] ins;
    logic [3:0]  d;
    chk({tag, ".in_ready"}, 64'(ir), 64'(size < 2));
    chk({tag, ".out_valid"}, 64'(ov), 64'(size > 0));
    if (size > 0) begin
      ins = head[31:0];
      d   = exp_dec(ins);
      chk({tag, ".pc_out"}, 64'(pco), 64'(head[63:32]));
      chk({tag, ".unextend_data"}, 64'(ud), 64'(ins >> 7));
      chk({tag, ".imm_type"}, 64'(it), 64'(d[2:0]));
      chk({tag, ".illegal"}, 64'(il), 64'(d[3]));
      chk({tag, ".fields"}, 64'({r1, r2, rdd, opc, f3, f7}),
          64'({ins[19:15], ins[24:20], ins[11:7], ins[6:0], ins[14:12], ins[31:25]}));
    end
  endtask

  // Called at posedge+1: drive inputs, check state left by the last edge,
  // advance the FIFO model, step to next posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    logic [63:0] ha, hb;
    logic [3:0]  d;
    logic        acc_a, acc_b, pop_a, pop_b;
    in_valid = iv; instr_in = ins; pc_in = pc; flush = fl; out_ready = ordy;
    ha = (qa.size() > 0) ? qa[0] : 64'h0;
    hb = (qb.size() > 0) ? qb[0] : 64'h0;
    check_port("a", qa.size(), ha, a_in_ready, a_out_valid, a_pc_out, a_ud, a_imm, a_illegal,
               a_rs1, a_rs2, a_rd, a_opc, a_f3, a_f7);
    check_port("b", qb.size(), hb, b_in_ready, b_out_valid, b_pc_out, b_ud, b_imm, b_illegal,
               b_rs1, b_rs2, b_rd, b_opc, b_f3, b_f7);
    if (a_out_valid && ordy) popped.push_back(a_pc_out);
    d     = exp_dec(ins);
    acc_a = iv && (qa.size() < 2);
    acc_b = iv && (qb.size() < 2);
    pop_a = (qa.size() > 0) && ordy;
    pop_b = (qb.size() > 0) && ordy;
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (acc_a) qa.push_back({pc, ins});
      if (pop_b) void'(qb.pop_front());
      if (acc_b && !d[3]) qb.push_back({pc, ins});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr_in = '0; pc_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  logic [31:0] pool[11];

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h100, 3'b000, 1'b0};  // addi x1,x0,-1
    vecs[1]  = '{32'h00112623, 32'h104, 3'b001, 1'b0};  // sw
    vecs[2]  = '{32'h00208463, 32'h108, 3'b010, 1'b0};  // beq
    vecs[3]  = '{32'h008000EF, 32'h10C, 3'b011, 1'b0};  // jal
    vecs[4]  = '{32'h123452B7, 32'h110, 3'b100, 1'b0};  // lui
    vecs[5]  = '{32'h00000517, 32'h114, 3'b100, 1'b0};  // auipc
    vecs[6]  = '{32'h00012083, 32'h118, 3'b000, 1'b0};  // lw
    vecs[7]  = '{32'h000080E7, 32'h11C, 3'b000, 1'b0};  // jalr
    vecs[8]  = '{32'h002081B3, 32'h120, 3'b000, 1'b0};  // add
    vecs[9]  = '{32'h0000007F, 32'h124, 3'b000, 1'b1};  // illegal
    vecs[10] = '{32'h0000000B, 32'h128, 3'b000, 1'b1};  // illegal (custom-0)
    for (int i = 0; i < 11; i++) pool[i] = vecs[i].instr;

    do_reset();
    chk("reset.out_valid", 64'(a_out_valid), 64'd0);
    chk("reset.in_ready", 64'(a_in_ready), 64'd1);
    chk("reset.data", 64'({a_pc_out, a_ud, a_imm, a_illegal}), 64'd0);

    // Decode table: one instruction at a time through an empty buffer
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, vecs[i].instr, vecs[i].pc, 1'b0, 1'b1);
      chk("tbl.a_out_valid", 64'(a_out_valid), 64'd1);
      chk("tbl.a_imm_type", 64'(a_imm), 64'(vecs[i].imm));
      chk("tbl.a_illegal", 64'(a_illegal), 64'(vecs[i].ill));
      chk("tbl.b_out_valid", 64'(b_out_valid), 64'(!vecs[i].ill));
      if (i == 0) begin
        chk("addi.unextend", 64'(a_ud), 64'h1FFE001);
        chk("addi.rd", 64'(a_rd), 64'd1);
        chk("addi.pc", 64'(a_pc_out), 64'h100);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end

    // Back-to-back with a stalled consumer, then drain
    popped.delete();
    cycle(1'b1, pool[0], 32'h200, 1'b0, 1'b0);
    cycle(1'b1, pool[1], 32'h204, 1'b0, 1'b0);
    chk("b2b.in_ready_low", 64'(a_in_ready), 64'd0);
    chk("b2b.head_held", 64'(a_pc_out), 64'h200);
    cycle(1'b1, pool[2], 32'h208, 1'b0, 1'b0);   // blocked, offer held
    chk("b2b.head_stable", 64'(a_pc_out), 64'h200);
    cycle(1'b1, pool[2], 32'h208, 1'b0, 1'b1);   // pop, skid -> main
    cycle(1'b1, pool[2], 32'h208, 1'b0, 1'b1);   // in_ready back, accepted
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("b2b.count", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      chk("b2b.order0", 64'(popped[0]), 64'h200);
      chk("b2b.order1", 64'(popped[1]), 64'h204);
      chk("b2b.order2", 64'(popped[2]), 64'h208);
    end

    // Flush with both entries held and a new instruction offered
    popped.delete();
    cycle(1'b1, pool[3], 32'h300, 1'b0, 1'b0);
    cycle(1'b1, pool[4], 32'h304, 1'b0, 1'b0);
    cycle(1'b1, pool[5], 32'h308, 1'b1, 1'b0);
    chk("flush.out_valid", 64'(a_out_valid), 64'd0);
    chk("flush.in_ready", 64'(a_in_ready), 64'd1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("flush.nothing_emerged", 64'(popped.size()), 64'd0);
    // Flush while popping and offering with room available
    cycle(1'b1, pool[6], 32'h310, 1'b0, 1'b1);
    cycle(1'b1, pool[7], 32'h314, 1'b1, 1'b1);
    chk("flush2.out_valid", 64'(a_out_valid), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset between edges with data in flight
    cycle(1'b1, pool[8], 32'h400, 1'b0, 1'b0);
    cycle(1'b1, pool[0], 32'h404, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.a_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst.b_out_valid", 64'(b_out_valid), 64'd0);
    chk("arst.in_ready", 64'(a_in_ready), 64'd1);
    chk("arst.data", 64'({a_pc_out, a_ud, a_imm}), 64'd0);
    qa.delete();
    qb.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef IF_ID_PERF_CNT_EN
    do_reset();
    cycle(1'b1, pool[0], 32'h500, 1'b0, 1'b0);
    cycle(1'b1, pool[1], 32'h504, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, pool[2], 32'h508, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("perf.stall_cnt", 64'(a_stall), 64'd5);
    chk("perf.flush_cnt", 64'(a_flush), 64'd2);
`endif

    // Random traffic against the FIFO model
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] r, ins;
      r   = $urandom();
      ins = pool[$urandom_range(0, 10)];
      ins = {r[31:7], ins[6:0]};
      cycle(($urandom_range(0, 3) != 0), ins, $urandom(),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_decode_buffer.md
Name: if_id_decode_buffer

Overview:
- IF/ID boundary stage of the RISC-V core, directly upstream of the immediate extender.
- Captures fetched instruction and PC through a valid/ready handshake and holds them in a 2-entry skid buffer.
- Pre-decodes the opcode into the immediate-format select and presents the raw immediate field bits to the extender, plus register fields to the register file.
- Supports pipeline flush on branch/jump redirect.

Parameters:
- XLEN, 32, width of PC and instruction.
- ILLEGAL_AS_NOP, 1, if 1 an illegal opcode is forwarded with illegal=1 and imm_type=000; if 0 it is dropped (never presented).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept; equals ~skid_valid (registered).
- instr_in  in  XLEN  fetched instruction.
- pc_in  in  XLEN  PC of instr_in.
- flush  in  1  discard all held and incoming entries this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute stage accepts head.
- pc_out  out  XLEN  PC of head.
- unextend_data  out  25  head instr[31:7], raw bits for the immediate extender.
- imm_type  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- rs1, rs2, rd  out  5 each  instr[19:15], [24:20], [11:7].
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- illegal  out  1  head opcode not in supported set.

Behaviour:
- Reset (async, immediate): main_valid=0, skid_valid=0, out_valid=0, in_ready=1. All data outputs are 0, so imm_type=000 and illegal=0.
- Entry: {pc, instr, imm_type, illegal}. Decode happens at capture, and the decoded fields are stored with the entry.
- Opcode map:
  - 0010011, 0000011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111, 0010111 -> U
  - 0110011 -> imm_type 000, illegal=0
  - any other -> illegal=1, imm_type 000
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Latency: an instruction accepted in cycle N is on the outputs with out_valid=1 in cycle N+1 when the buffer was empty.
- Both entries empty + accept: main loads.
- Main full + pop + accept: main loads the new entry.
- Main full + no pop + accept: skid loads, and in_ready falls next cycle.
- Skid full + pop: main <- skid, skid_valid=0, in_ready rises next cycle. No accept is possible that cycle because in_ready=0.
- Pop with no accept and skid empty: main_valid=0.
- Order is strictly FIFO. No entry is lost or duplicated.
- Outputs are driven only from the main register. They are held stable while out_valid=1 and out_ready=0.
- flush (sync, highest priority): next cycle main_valid=0 and skid_valid=0, and in_ready=1. An instruction offered in the flush cycle is discarded, and a pop in the flush cycle is still counted as consumed downstream.
- ILLEGAL_AS_NOP=0: an illegal instruction is accepted, but its entry is not written.
- Data registers need not clear on pop. Only the valid bits matter, except after reset.
- Reset mid-transfer: all entries are lost, with no partial state.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with in_valid & ~in_ready.
  - flush_cnt increments each cycle with flush=1.
  - Both reset to 0 on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package: opcode constants (OP_IMM, LOAD, JALR, STORE, BRANCH, JAL, LUI, AUIPC, OP) and imm_type encodings I_TYPE..U_TYPE. These are the same values the immediate extender uses and must come from this single source.
- One natural sub-module: opcode_predecode (combinational: opcode -> imm_type, illegal). It is instantiated once on the capture path.

Test Plan:
- Reset then in_valid=1, instr_in=0xFFF00093 (addi x1,x0,-1), pc_in=0x100, out_ready=1 -> next cycle out_valid=1, imm_type=000, unextend_data=0x1FFE001, rd=1, pc_out=0x100.
- Three back-to-back instructions with out_ready=0 -> first in main, second in skid, in_ready=0 in cycle 3. Raise out_ready -> outputs appear in order 1,2,3 with no loss.
- sw 0x00112623 -> imm_type=001. beq 0x00208463 -> 010. jal 0x008000EF -> 011. lui 0x123452B7 -> 100.
- Instruction 0x0000007F -> illegal=1, imm_type=000 (ILLEGAL_AS_NOP=1). With ILLEGAL_AS_NOP=0 it never appears on out_valid.
- Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction never emerges.
- rst asserted mid-stream, between clock edges -> out_valid drops immediately. With IF_ID_PERF_CNT_EN, 5 blocked cycles followed by 2 flushes give stall_cnt=5 and flush_cnt=2.
